// File: rtl/host_sequencer_if.sv
// Signal bundle between the host sequencer and its environment: upstream sample
// stream, MCU/ASIC status bytes, sample bytes and the captured tone result.
interface host_sequencer_if;
    logic        start_req;
    logic        s_valid;
    logic [15:0] s_data;
    logic        s_ready;
    logic [7:0]  mcu_status_lsb;
    logic [7:0]  mcu_status_msb;
    logic [7:0]  sample_lsb;
    logic [7:0]  sample_msb;
    logic [7:0]  asic_status_lsb;
    logic [7:0]  result_lsb;
    logic [7:0]  result_msb;
    logic [15:0] tone;
    logic        tone_valid;
    logic        busy;
    logic        timeout_err;

    modport master (
        input  start_req, s_valid, s_data, asic_status_lsb, result_lsb, result_msb,
        output s_ready, mcu_status_lsb, mcu_status_msb, sample_lsb, sample_msb,
        output tone, tone_valid, busy, timeout_err
    );

    modport slave (
        output start_req, s_valid, s_data, asic_status_lsb, result_lsb, result_msb,
        input  s_ready, mcu_status_lsb, mcu_status_msb, sample_lsb, sample_msb,
        input  tone, tone_valid, busy, timeout_err
    );
endinterface

// File: rtl/host_sequencer.sv
// Host-side frame sequencer: feeds NSAMP upstream samples to the ASIC one at a time
// over a status-byte handshake, then collects the tone result, with per-state timeouts.
module host_sequencer #(
    parameter int unsigned NSAMP   = 128,
    parameter int unsigned TIMEOUT = 4096
) (
    input logic              clk,
    input logic              reset_n,
    host_sequencer_if.master bus
);
    localparam int unsigned CNT_W = $clog2(NSAMP + 1);
    localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, START, LOAD, FEED, DRAIN, ACK, ERR} state_t;

    state_t           state;
    logic [CNT_W-1:0] samp_cnt;
    logic [TMO_W-1:0] tmo_cnt;
    logic             rfs_q;
    logic             st_valid;
    logic             st_ack;
    logic             st_start;
    logic [15:0]      sample_q;
    logic             consume_c;
    logic             tmo_hit_c;
    logic             last_samp_c;
    logic             timed_c;
    logic             progress_c;
    logic             unused_asic;

    // A consumed sample is the ASIC dropping ready-for-sample after having shown it.
    assign consume_c   = rfs_q & ~bus.asic_status_lsb[3];
    assign tmo_hit_c   = (tmo_cnt == TMO_W'(TIMEOUT - 1));
    assign last_samp_c = (samp_cnt == CNT_W'(NSAMP - 1));
    assign timed_c     = (state == START) || (state == FEED) || (state == DRAIN) || (state == ACK);
    assign unused_asic = ^{bus.asic_status_lsb[7:4], bus.asic_status_lsb[1]};

    assign bus.mcu_status_lsb = {5'b0, st_start, st_ack, st_valid};
    assign bus.mcu_status_msb = 8'h00;
    assign bus.sample_lsb     = sample_q[7:0];
    assign bus.sample_msb     = sample_q[15:8];

    // Event that lets each watched state move on; absent, its timeout keeps running.
    always_comb begin
        progress_c = 1'b0;
        case (state)
            START:   progress_c = bus.asic_status_lsb[2];
            FEED:    progress_c = consume_c;
            DRAIN:   progress_c = bus.asic_status_lsb[0];
            ACK:     progress_c = ~bus.asic_status_lsb[0];
            default: progress_c = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state           <= IDLE;
            samp_cnt        <= '0;
            tmo_cnt         <= '0;
            rfs_q           <= 1'b0;
            st_valid        <= 1'b0;
            st_ack          <= 1'b0;
            st_start        <= 1'b0;
            sample_q        <= '0;
            bus.s_ready     <= 1'b0;
            bus.tone        <= '0;
            bus.tone_valid  <= 1'b0;
            bus.busy        <= 1'b0;
            bus.timeout_err <= 1'b0;
        end else begin
            bus.tone_valid <= 1'b0;
            rfs_q          <= bus.asic_status_lsb[3];
            tmo_cnt        <= '0;

            case (state)
                IDLE, ERR: begin
                    if (bus.start_req) begin
                        state           <= START;
                        st_start        <= 1'b1;
                        bus.busy        <= 1'b1;
                        bus.timeout_err <= 1'b0;
                        samp_cnt        <= '0;
                        rfs_q           <= 1'b0;
                    end
                end
                START: begin
                    if (progress_c) begin
                        st_start    <= 1'b0;
                        bus.s_ready <= 1'b1;
                        state       <= LOAD;
                    end
                end
                LOAD: begin
                    if (bus.s_valid && bus.s_ready) begin
                        sample_q    <= bus.s_data;
                        st_valid    <= 1'b1;
                        bus.s_ready <= 1'b0;
                        state       <= FEED;
                    end
                end
                FEED: begin
                    if (progress_c) begin
                        samp_cnt <= samp_cnt + CNT_W'(1);
                        st_valid <= 1'b0;
                        if (last_samp_c) begin
                            state <= DRAIN;
                        end else begin
                            state       <= LOAD;
                            bus.s_ready <= 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (progress_c) begin
                        bus.tone       <= {bus.result_msb, bus.result_lsb};
                        bus.tone_valid <= 1'b1;
                        st_ack         <= 1'b1;
                        state          <= ACK;
                    end
                end
                ACK: begin
                    if (progress_c) begin
                        st_ack   <= 1'b0;
                        bus.busy <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase

            // Stalled ASIC handshake: count, and abandon the frame once the budget is spent.
            if (timed_c && !progress_c) begin
                if (tmo_hit_c) begin
                    state           <= ERR;
                    st_start        <= 1'b0;
                    st_valid        <= 1'b0;
                    st_ack          <= 1'b0;
                    bus.timeout_err <= 1'b1;
                end else begin
                    tmo_cnt <= tmo_cnt + TMO_W'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_host_sequencer.sv
// Randomized bench for host_sequencer: a behavioural ASIC and upstream source check
// every presented sample, the tone result, timeouts and mid-frame reset.
module tb_host_sequencer;
    localparam int NSAMP   = 128;
    localparam int TIMEOUT = 4096;
    localparam int LIM     = 2 * TIMEOUT;
    localparam int DT      = NSAMP + 4;

    localparam int C_START   = 0;
    localparam int C_NOSTART = 1;
    localparam int C_VALID   = 2;
    localparam int C_ACKB    = 3;
    localparam int C_TERR    = 4;

    logic clk = 1'b0;
    logic reset_n;

    host_sequencer_if bus ();

    host_sequencer #(.NSAMP(NSAMP), .TIMEOUT(TIMEOUT)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Upstream source: presents data_tab in order, optionally gappy or stalled.
    logic [15:0] data_tab [DT];
    bit          drv_en      = 1'b0;
    bit          rand_valid  = 1'b0;
    int          idx         = 0;
    int          accepted    = 0;
    int          stall_after = -1;
    int          stall_len   = 0;
    int          stall_left  = 0;

    initial begin
        bus.s_valid = 1'b0;
        bus.s_data  = '0;
        forever begin
            @(negedge clk);
            if (!drv_en || idx >= DT) begin
                bus.s_valid = 1'b0;
            end else begin
                if (stall_left > 0) begin
                    bus.s_valid = 1'b0;
                    stall_left--;
                end else begin
                    bus.s_valid = rand_valid ? ($urandom_range(0, 3) != 0) : 1'b1;
                end
                bus.s_data = data_tab[idx];
                if (bus.s_valid && bus.s_ready) begin
                    accepted++;
                    idx++;
                    if (accepted == stall_after) stall_left = stall_len;
                end
            end
        end
    end

    // Status-byte invariants and tone_valid pulse count, watched every cycle.
    int tv_pulses = 0;
    int excl_viol = 0;

    always @(negedge clk) begin
        if (reset_n) begin
            if (bus.tone_valid) tv_pulses++;
            if ($countones(bus.mcu_status_lsb[2:0]) > 1 || bus.mcu_status_lsb[7:3] != 5'd0 ||
                bus.mcu_status_msb != 8'h00 || (bus.mcu_status_lsb[2:0] != 3'd0 && !bus.busy) ||
                (bus.s_ready && bus.mcu_status_lsb[0]))
                excl_viol++;
        end
    end

    function automatic bit cond(input int w);
        case (w)
            C_START:   return bus.mcu_status_lsb[2];
            C_NOSTART: return !bus.mcu_status_lsb[2];
            C_VALID:   return bus.mcu_status_lsb[0];
            C_ACKB:    return bus.mcu_status_lsb[1];
            C_TERR:    return bus.timeout_err;
            default:   return 1'b1;
        endcase
    endfunction

    task automatic wait_chk(input int w, input string tag, output bit ok, output int n);
        n = 0;
        while (!cond(w) && n < LIM) begin
            @(negedge clk);
            n++;
        end
        ok = cond(w);
        check(tag, 32'(ok), 1);
    endtask

    task automatic check_zero(input string pfx);
        check({pfx, "_s_ready"},     32'(bus.s_ready), 0);
        check({pfx, "_mcu_lsb"},     32'(bus.mcu_status_lsb), 0);
        check({pfx, "_mcu_msb"},     32'(bus.mcu_status_msb), 0);
        check({pfx, "_sample_lsb"},  32'(bus.sample_lsb), 0);
        check({pfx, "_sample_msb"},  32'(bus.sample_msb), 0);
        check({pfx, "_tone"},        32'(bus.tone), 0);
        check({pfx, "_tone_valid"},  32'(bus.tone_valid), 0);
        check({pfx, "_busy"},        32'(bus.busy), 0);
        check({pfx, "_timeout_err"}, 32'(bus.timeout_err), 0);
    endtask

    // Behavioural ASIC for one frame; returns early on hang, reset or a missed handshake.
    task automatic asic_frame(input logic [15:0] res, input int hang_at, input int rst_at,
                              input int poke_at, input int stall_chk, output bit aborted);
        bit ok;
        int n;
        int gap;
        aborted = 1'b1;
        wait_chk(C_START, "start_seen", ok, n);
        if (!ok) return;
        bus.asic_status_lsb[2] = 1'b1;
        wait_chk(C_NOSTART, "start_drop", ok, n);
        if (!ok) return;
        bus.asic_status_lsb[2] = 1'b0;

        for (int i = 0; i < NSAMP; i++) begin
            bus.asic_status_lsb[3] = 1'b1;
            @(negedge clk);
            if (i == hang_at) return;
            wait_chk(C_VALID, "sample_valid", ok, n);
            if (!ok) return;
            if (i == poke_at) begin
                bus.start_req = 1'b1;
                @(negedge clk);
                bus.start_req = 1'b0;
                check("poke_hold_bit0", 32'(bus.mcu_status_lsb[0]), 1);
                check("poke_no_restart", 32'(bus.mcu_status_lsb[2]), 0);
            end
            check("sample_data", 32'({bus.sample_msb, bus.sample_lsb}), 32'(data_tab[i]));
            bus.asic_status_lsb[3] = 1'b0;
            if (i + 1 == rst_at) begin
                reset_n = 1'b0;
                drv_en  = 1'b0;
                @(negedge clk);
                reset_n = 1'b1;
                check_zero("rst_mid");
                return;
            end
            gap = $urandom_range(5, 8);
            for (int g = 0; g < gap; g++) begin
                @(negedge clk);
                if (g == 0) begin
                    check("consume_bit0", 32'(bus.mcu_status_lsb[0]), 0);
                    check("consume_ready", 32'(bus.s_ready), (i < NSAMP - 1) ? 1 : 0);
                end
                if (i == stall_chk && g == 2) begin
                    check("stall_bit0", 32'(bus.mcu_status_lsb[0]), 0);
                    check("stall_ready", 32'(bus.s_ready), 1);
                    check("stall_terr", 32'(bus.timeout_err), 0);
                end
            end
        end

        check("drain_status", 32'(bus.mcu_status_lsb), 0);
        check("drain_busy", 32'(bus.busy), 1);
        check("drain_ready", 32'(bus.s_ready), 0);
        check("drain_accepted", 32'(accepted), NSAMP);
        bus.asic_status_lsb[1] = 1'b1;
        repeat ($urandom_range(2, 10)) @(negedge clk);
        check("drain_no_tone", 32'(tv_pulses), 0);
        bus.result_lsb = res[7:0];
        bus.result_msb = res[15:8];
        bus.asic_status_lsb[1] = 1'b0;
        bus.asic_status_lsb[0] = 1'b1;
        wait_chk(C_ACKB, "ack_seen", ok, n);
        if (!ok) return;
        check("tone", 32'(bus.tone), 32'(res));
        repeat ($urandom_range(1, 5)) @(negedge clk);
        check("ack_hold", 32'(bus.mcu_status_lsb[1]), 1);
        bus.asic_status_lsb[0] = 1'b0;
        @(negedge clk);
        check("ack_clear", 32'(bus.mcu_status_lsb), 0);
        check("idle_busy", 32'(bus.busy), 0);
        aborted = 1'b0;
    endtask

    task automatic run_frame(input logic [15:0] res, input bit rv, input bit rd,
                             input int st_after, input int st_len, input int st_chk,
                             input int poke_at, input int hang_at, input int rst_at,
                             output bit aborted);
        @(negedge clk);
        drv_en      = 1'b0;
        idx         = 0;
        accepted    = 0;
        stall_left  = 0;
        stall_after = st_after;
        stall_len   = st_len;
        rand_valid  = rv;
        for (int i = 0; i < DT; i++) data_tab[i] = rd ? 16'($urandom) : 16'(i);
        tv_pulses           = 0;
        excl_viol           = 0;
        bus.asic_status_lsb = 8'h00;
        bus.start_req       = 1'b1;
        @(negedge clk);
        bus.start_req = 1'b0;
        check("start_busy", 32'(bus.busy), 1);
        check("start_terr", 32'(bus.timeout_err), 0);
        check("start_status", 32'(bus.mcu_status_lsb), 32'h04);
        drv_en = 1'b1;
        asic_frame(res, hang_at, rst_at, poke_at, st_chk, aborted);
        if (!aborted) begin
            repeat (2) @(negedge clk);
            check("frame_accepted", 32'(accepted), NSAMP);
            check("frame_tone_pulses", 32'(tv_pulses), 1);
            check("frame_terr", 32'(bus.timeout_err), 0);
        end
        check("status_invariants", 32'(excl_viol), 0);
        drv_en = 1'b0;
    endtask

    initial begin
        #4_000_000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        bit ab;
        int n;
        bit ok;
        reset_n             = 1'b0;
        bus.start_req       = 1'b0;
        bus.asic_status_lsb = 8'h00;
        bus.result_lsb      = 8'h00;
        bus.result_msb      = 8'h00;
        repeat (3) @(negedge clk);
        check_zero("reset");
        reset_n = 1'b1;

        // Ordered data, always valid, fixed result.
        run_frame(16'h1234, 1'b0, 1'b0, -1, 0, -1, -1, -1, -1, ab);
        check("full_frame_done", 32'(ab), 0);

        // Short upstream stall after sample 5.
        run_frame(16'($urandom), 1'b0, 1'b0, 6, 20, 5, -1, -1, -1, ab);

        // Random data and gappy valid, start_req poked while a sample is presented.
        run_frame(16'($urandom), 1'b1, 1'b1, -1, 0, -1, 10, -1, -1, ab);

        // Reset after 60 samples, then a full frame must start from zero.
        run_frame(16'h5a5a, 1'b0, 1'b1, -1, 0, -1, -1, -1, 60, ab);
        check("rst_no_tone", 32'(tv_pulses), 0);
        @(negedge clk);
        check("rst_idle_busy", 32'(bus.busy), 0);
        run_frame(16'($urandom), 1'b0, 1'b1, -1, 0, -1, -1, -1, -1, ab);

        // ASIC hangs with ready-for-sample stuck high.
        run_frame(16'h0bad, 1'b0, 1'b1, -1, 0, -1, -1, 30, -1, ab);
        wait_chk(C_TERR, "hang_terr", ok, n);
        check("hang_latency", 32'((n >= TIMEOUT - 12) && (n <= TIMEOUT + 2)), 1);
        check("hang_status", 32'(bus.mcu_status_lsb), 0);
        check("hang_busy", 32'(bus.busy), 1);
        check("hang_ready", 32'(bus.s_ready), 0);
        repeat (10) @(negedge clk);
        check("err_hold_terr", 32'(bus.timeout_err), 1);
        check("err_hold_busy", 32'(bus.busy), 1);

        // Recovery from ERR, then a stall longer than the handshake timeout.
        run_frame(16'($urandom), 1'b1, 1'b1, -1, 0, -1, -1, -1, -1, ab);
        run_frame(16'($urandom), 1'b0, 1'b1, 40, TIMEOUT + 50, 39, -1, -1, -1, ab);

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
